// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC test design serial path.
// Both the transmitter and the receiver side use these.
package cdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/cdc_bit_timer.sv
// Loadable down-counter with a zero flag. It paces serial bit periods.
// A load takes priority over counting, and the count holds at zero.
module cdc_bit_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cdc_serial_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// A one-entry holding buffer lets consecutive frames leave with no idle gap.
module cdc_serial_tx
  import cdc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = 8,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic [7:0]        frame_count
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] RELOAD   = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_t state, state_next;

  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              hold_full_next;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [IW-1:0]     bit_idx;
  logic [IW-1:0]     bit_idx_next;
  logic              parity_bit;
  logic              accept;
  logic              load_frame;
  logic              shift_en;
  logic              frame_done;
  logic              timer_load;
  logic              timer_zero;
  logic              tx_out_next;

  cdc_bit_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (RELOAD),
    .zero       (timer_zero)
  );

  assign accept  = tx_valid && tx_ready;
  assign shifted = shreg >> 1;

  // tx_out_next is the level the line takes in the state being entered.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    load_frame   = 1'b0;
    shift_en     = 1'b0;
    frame_done   = 1'b0;
    timer_load   = 1'b0;
    tx_out_next  = tx_out;
    case (state)
      IDLE: begin
        tx_out_next = IDLE_LEVEL;
        if (hold_full) begin
          load_frame  = 1'b1;
          timer_load  = 1'b1;
          state_next  = START;
          tx_out_next = START_LEVEL;
        end
      end
      START: begin
        if (timer_zero) begin
          timer_load   = 1'b1;
          bit_idx_next = '0;
          state_next   = DATA;
          tx_out_next  = shreg[0];
        end
      end
      DATA: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          if (bit_idx == LAST_IDX) begin
            if (PARITY_EN) begin
              state_next  = PARITY;
              tx_out_next = parity_bit;
            end else begin
              state_next  = STOP;
              tx_out_next = IDLE_LEVEL;
            end
          end else begin
            bit_idx_next = bit_idx + IW'(1);
            shift_en     = 1'b1;
            tx_out_next  = shifted[0];
          end
        end
      end
      PARITY: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          state_next  = STOP;
          tx_out_next = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (timer_zero) begin
          frame_done = 1'b1;
          if (hold_full) begin
            load_frame  = 1'b1;
            timer_load  = 1'b1;
            state_next  = START;
            tx_out_next = START_LEVEL;
          end else begin
            state_next  = IDLE;
            tx_out_next = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        tx_out_next = IDLE_LEVEL;
      end
    endcase
  end

  // An accept in the same cycle as a drain leaves the buffer full with the new byte.
  always_comb begin
    hold_full_next = hold_full;
    if (accept) begin
      hold_full_next = 1'b1;
    end else if (load_frame) begin
      hold_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      tx_ready    <= 1'b1;
      tx_out      <= IDLE_LEVEL;
      frame_count <= 8'd0;
      bit_idx     <= '0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
    end else begin
      state     <= state_next;
      hold_full <= hold_full_next;
      tx_ready  <= !hold_full_next;
      tx_out    <= tx_out_next;
      bit_idx   <= bit_idx_next;
      if (accept) begin
        hold_data <= tx_data;
      end
      if (load_frame) begin
        shreg      <= hold_data;
        parity_bit <= ^hold_data;
      end else if (shift_en) begin
        shreg <= shifted;
      end
      if (frame_done) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_cdc_serial_tx.sv
// Self-checking bench for cdc_serial_tx: instance a (4 clks/bit, parity) and
// instance b (2 clks/bit, no parity), with a line monitor decoding instance a.
module tb_cdc_serial_tx;

  localparam int CPB_A   = 4;
  localparam int BITS_A  = 11;
  localparam int CPB_B   = 2;
  localparam int BITS_B  = 10;
  localparam int LIMIT   = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_out_a, tx_out_b;
  logic       busy_a, busy_b;
  logic [7:0] frame_count_a, frame_count_b;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  logic [10:0] mon_frame[$];
  bit          mon_glitch[$];
  int          mon_start[$];
  int          mon_gap[$];
  int          last_end = -1000;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    logic [7:0]  count;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cdc_serial_tx #(.CLKS_PER_BIT(CPB_A), .DATA_W(8), .PARITY_EN(1'b1)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data_a),
    .tx_valid    (tx_valid_a),
    .tx_ready    (tx_ready_a),
    .tx_out      (tx_out_a),
    .busy        (busy_a),
    .frame_count (frame_count_a)
  );

  cdc_serial_tx #(.CLKS_PER_BIT(CPB_B), .DATA_W(8), .PARITY_EN(1'b0)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data_b),
    .tx_valid    (tx_valid_b),
    .tx_ready    (tx_ready_b),
    .tx_out      (tx_out_b),
    .busy        (busy_b),
    .frame_count (frame_count_b)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passed++;
  endtask

  // Line monitor for instance a: every cycle of a frame must hold its bit's level.
  initial begin
    logic [10:0] frame;
    bit          glitch;
    int          start;
    forever begin
      @(negedge clk);
      if (!rst && tx_out_a == 1'b0) begin
        start  = cyc;
        frame  = '0;
        glitch = 1'b0;
        for (int i = 0; i < BITS_A * CPB_A; i++) begin
          if (i > 0) @(negedge clk);
          if (i % CPB_A == 0) frame[i / CPB_A] = tx_out_a;
          else if (tx_out_a != frame[i / CPB_A]) glitch = 1'b1;
        end
        mon_frame.push_back(frame);
        mon_glitch.push_back(glitch);
        mon_start.push_back(start);
        mon_gap.push_back(start - last_end - 1);
        last_end = cyc;
      end
    end
  end

  function automatic logic ready_of(input bit sel);
    return sel ? tx_ready_b : tx_ready_a;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic apply_stimulus(input bit sel, input logic [7:0] data,
                                output int waits, output int acc_cyc);
    waits = 0;
    if (sel) begin tx_valid_b = 1'b1; tx_data_b = data; end
    else     begin tx_valid_a = 1'b1; tx_data_a = data; end
    while (!ready_of(sel) && waits < LIMIT) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= LIMIT) check_output("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    acc_cyc = cyc;
    if (sel) tx_valid_b = 1'b0;
    else     tx_valid_a = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while (busy_of(sel) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_output("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic expect_frame(input string name, input logic [10:0] exp,
                              output int start, output int gap);
    start = -1;
    gap   = -1;
    if (mon_frame.size() == 0) begin
      check_output({name, "_present"}, 32'd0, 32'd1);
    end else begin
      check_output({name, "_frame"}, 32'(mon_frame.pop_front()), 32'(exp));
      check_output({name, "_stable"}, 32'(mon_glitch.pop_front()), 32'd0);
      start = mon_start.pop_front();
      gap   = mon_gap.pop_front();
    end
  endtask

  initial begin
    int w, w2, w3, acc, acc2, acc3, st, gp;
    logic [9:0] frame_b;
    bit glitch_b;

    rst = 1'b1;
    tx_valid_a = 1'b0; tx_data_a = 8'h00;
    tx_valid_b = 1'b0; tx_data_b = 8'h00;

    vecs[0] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 8'd2};
    vecs[1] = '{8'h7F, {1'b1, 1'b1, 8'h7F, 1'b0}, 8'd3};
    vecs[2] = '{8'h01, {1'b1, 1'b1, 8'h01, 1'b0}, 8'd4};
    vecs[3] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 8'd5};
    vecs[4] = '{8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 8'd6};

    repeat (3) @(negedge clk);
    check_output("rst_tx_out_a", 32'(tx_out_a), 32'd1);
    check_output("rst_ready_a", 32'(tx_ready_a), 32'd1);
    check_output("rst_busy_a", 32'(busy_a), 32'd0);
    check_output("rst_count_a", 32'(frame_count_a), 32'd0);
    check_output("rst_tx_out_b", 32'(tx_out_b), 32'd1);
    check_output("rst_count_b", 32'(frame_count_b), 32'd0);
    rst = 1'b0;

    // Abort 0x5A during data bit 3 (line-cycle 17 of the frame).
    apply_stimulus(1'b0, 8'h5A, w, acc);
    repeat (18) @(negedge clk);
    check_output("mid_busy", 32'(busy_a), 32'd1);
    check_output("mid_bit3", 32'(tx_out_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_tx_out", 32'(tx_out_a), 32'd1);
    check_output("abort_busy", 32'(busy_a), 32'd0);
    check_output("abort_ready", 32'(tx_ready_a), 32'd1);
    check_output("abort_count", 32'(frame_count_a), 32'd0);
    repeat (60) @(negedge clk);
    mon_frame.delete(); mon_glitch.delete(); mon_start.delete(); mon_gap.delete();
    last_end = -1000;

    apply_stimulus(1'b0, 8'h81, w, acc);
    wait_idle(1'b0);
    expect_frame("after_abort_81", {1'b1, 1'b0, 8'h81, 1'b0}, st, gp);
    check_output("after_abort_count", 32'(frame_count_a), 32'd1);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, vecs[i].data, w, acc);
      check_output($sformatf("vec%0d_line_idle_at_accept", i), 32'(tx_out_a), 32'd1);
      check_output($sformatf("vec%0d_ready_low", i), 32'(tx_ready_a), 32'd0);
      wait_idle(1'b0);
      expect_frame($sformatf("vec%0d", i), vecs[i].frame, st, gp);
      check_output($sformatf("vec%0d_latency", i), 32'(st - acc), 32'd1);
      check_output($sformatf("vec%0d_count", i), 32'(frame_count_a), 32'(vecs[i].count));
      check_output($sformatf("vec%0d_busy", i), 32'(busy_a), 32'd0);
    end

    apply_stimulus(1'b0, 8'h00, w, acc);
    apply_stimulus(1'b0, 8'hFF, w2, acc2);
    wait_idle(1'b0);
    expect_frame("b2b_00", {1'b1, 1'b0, 8'h00, 1'b0}, st, gp);
    expect_frame("b2b_ff", {1'b1, 1'b0, 8'hFF, 1'b0}, st, gp);
    check_output("b2b_gap", 32'(gp), 32'd0);
    check_output("b2b_count", 32'(frame_count_a), 32'd8);

    apply_stimulus(1'b0, 8'h11, w, acc);
    apply_stimulus(1'b0, 8'h22, w2, acc2);
    apply_stimulus(1'b0, 8'h33, w3, acc3);
    check_output("bp_wait1", 32'(w), 32'd0);
    check_output("bp_wait2", 32'(w2), 32'd1);
    check_output("bp_wait3", 32'(w3), 32'(BITS_A * CPB_A - 1));
    wait_idle(1'b0);
    expect_frame("bp_11", {1'b1, 1'b0, 8'h11, 1'b0}, st, gp);
    expect_frame("bp_22", {1'b1, 1'b0, 8'h22, 1'b0}, st, gp);
    check_output("bp_gap2", 32'(gp), 32'd0);
    expect_frame("bp_33", {1'b1, 1'b0, 8'h33, 1'b0}, st, gp);
    check_output("bp_gap3", 32'(gp), 32'd0);
    check_output("bp_extra", 32'(mon_frame.size()), 32'd0);
    check_output("bp_count", 32'(frame_count_a), 32'd11);

    // Instance b: 0x7F, no parity, 2 clocks per bit.
    apply_stimulus(1'b1, 8'h7F, w, acc);
    @(negedge clk);
    frame_b  = '0;
    glitch_b = 1'b0;
    for (int i = 0; i < BITS_B * CPB_B; i++) begin
      if (i > 0) @(negedge clk);
      if (i % CPB_B == 0) frame_b[i / CPB_B] = tx_out_b;
      else if (tx_out_b != frame_b[i / CPB_B]) glitch_b = 1'b1;
    end
    @(negedge clk);
    check_output("nopar_frame", 32'(frame_b), 32'({1'b1, 8'h7F, 1'b0}));
    check_output("nopar_stable", 32'(glitch_b), 32'd0);
    check_output("nopar_end_line", 32'(tx_out_b), 32'd1);
    check_output("nopar_end_busy", 32'(busy_b), 32'd0);
    check_output("nopar_count", 32'(frame_count_b), 32'd1);

    for (int i = 0; i < 254; i++) apply_stimulus(1'b1, 8'(i), w, acc);
    wait_idle(1'b1);
    check_output("wrap_255", 32'(frame_count_b), 32'd255);
    apply_stimulus(1'b1, 8'hC3, w, acc);
    wait_idle(1'b1);
    check_output("wrap_0", 32'(frame_count_b), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
